// File: rtl/calc_pkg.sv
// Shared key codes, operator/display encodings and FSM states for the calculator sequencer.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_EQU = 4'hD;
  localparam logic [3:0] KEY_MUL = 4'hE;
  localparam logic [3:0] KEY_F   = 4'hF;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MUL  = 2'b11
  } op_sel_e;

  typedef enum logic [1:0] {
    DISP_ZERO = 2'b00,
    DISP_A    = 2'b01,
    DISP_B    = 2'b10,
    DISP_RES  = 2'b11
  } disp_sel_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER_A = 3'd1,
    OP_WAIT = 3'd2,
    ENTER_B = 3'd3,
    EXEC    = 3'd4,
    RESULT  = 3'd5,
    ERROR   = 3'd6
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
  endfunction

  function automatic op_sel_e key_to_op(input logic [3:0] k);
    op_sel_e op;
    case (k)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// DIGITS-nibble BCD entry register: shift-in of new LS digit, right shift (backspace),
// parallel load and clear, with a count of significant digits entered.
module bcd_entry_reg #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  shift_in,
  input  logic [3:0]            digit,
  input  logic                  shift_out,
  output logic [4*DIGITS-1:0]   value,
  output logic                  cnt_le1
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  base_v, value_nxt;
  logic [CW-1:0] base_c, cnt_nxt;

  // clr combined with shift_in restarts entry with the new digit
  always_comb begin
    base_v    = clr ? '0 : value;
    base_c    = clr ? '0 : cnt;
    value_nxt = base_v;
    cnt_nxt   = base_c;
    if (load) begin
      value_nxt = load_value;
      cnt_nxt   = CW'(DIGITS);
    end else if (shift_in) begin
      // a leading zero leaves both value and count at zero
      if ((base_c < CW'(DIGITS)) && !((base_c == '0) && (digit == 4'd0))) begin
        value_nxt = {base_v[W-5:0], digit};
        cnt_nxt   = base_c + CW'(1);
      end
    end else if (shift_out) begin
      value_nxt = {4'h0, base_v[W-1:4]};
      cnt_nxt   = (base_c != '0) ? base_c - CW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= '0;
      cnt   <= '0;
    end else begin
      value <= value_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign cnt_le1 = (cnt <= CW'(1));

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: builds BCD operands from key events, runs the ALU handshake with
// timeout and selects the display source. Backspace on key F enabled by CALC_SEQ_BACKSPACE_EN.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                alu_done,
  input  logic [4*DIGITS-1:0] alu_result,
  input  logic                alu_err,
  output logic [4*DIGITS-1:0] op_a,
  output logic [4*DIGITS-1:0] op_b,
  output logic [1:0]          op_sel,
  output logic                alu_start,
  output logic [4*DIGITS-1:0] disp_value,
  output logic [1:0]          disp_sel,
  output logic                busy,
  output logic                error
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned TW = 8;

`ifdef CALC_SEQ_BACKSPACE_EN
  localparam bit BKSP_EN = 1'b1;
`else
  localparam bit BKSP_EN = 1'b0;
`endif

  state_e        state, state_nxt;
  op_sel_e       op_sel_q, op_sel_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [W-1:0]  res_q;
  logic          start_nxt, res_cap;

  logic a_clr, a_load, a_shin, a_shout, a_le1;
  logic b_clr, b_shin, b_shout, b_le1;

  logic k_dig, k_op, k_clr, k_equ, k_bs, tmo_hit;

  assign k_dig   = key_valid && is_digit(key_code);
  assign k_op    = key_valid && is_op(key_code);
  assign k_clr   = key_valid && (key_code == KEY_CLR);
  assign k_equ   = key_valid && (key_code == KEY_EQU);
  assign k_bs    = key_valid && BKSP_EN && (key_code == KEY_F);
  assign tmo_hit = (tmo_cnt == TW'(ALU_TIMEOUT));

  bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_a (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (a_clr),
    .load       (a_load),
    .load_value (res_q),
    .shift_in   (a_shin),
    .digit      (key_code),
    .shift_out  (a_shout),
    .value      (op_a),
    .cnt_le1    (a_le1)
  );

  bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_b (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (b_clr),
    .load       (1'b0),
    .load_value ('0),
    .shift_in   (b_shin),
    .digit      (key_code),
    .shift_out  (b_shout),
    .value      (op_b),
    .cnt_le1    (b_le1)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // C wins over everything, including a simultaneous alu_done
  always_comb begin
    state_nxt = state;
    if (k_clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (k_dig) state_nxt = ENTER_A;
        ENTER_A: begin
          if (k_op)                state_nxt = OP_WAIT;
          else if (k_bs && a_le1)  state_nxt = IDLE;
        end
        OP_WAIT: if (k_dig) state_nxt = ENTER_B;
        ENTER_B: begin
          if (k_equ)               state_nxt = EXEC;
          else if (k_bs && b_le1)  state_nxt = OP_WAIT;
        end
        EXEC: begin
          if (alu_done)            state_nxt = alu_err ? ERROR : RESULT;
          else if (tmo_hit)        state_nxt = ERROR;
        end
        RESULT: begin
          if (k_dig)               state_nxt = ENTER_A;
          else if (k_op)           state_nxt = OP_WAIT;
        end
        ERROR:   state_nxt = ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // operand register strobes and next operator/start
  always_comb begin
    a_clr      = 1'b0;
    a_load     = 1'b0;
    a_shin     = 1'b0;
    a_shout    = 1'b0;
    b_clr      = 1'b0;
    b_shin     = 1'b0;
    b_shout    = 1'b0;
    op_sel_nxt = op_sel_q;
    start_nxt  = 1'b0;
    res_cap    = 1'b0;
    if (k_clr) begin
      a_clr      = 1'b1;
      b_clr      = 1'b1;
      op_sel_nxt = OP_NONE;
    end else begin
      case (state)
        IDLE: a_shin = k_dig;
        ENTER_A: begin
          a_shin  = k_dig;
          a_shout = k_bs;
          if (k_op) op_sel_nxt = key_to_op(key_code);
        end
        OP_WAIT: begin
          if (k_op) op_sel_nxt = key_to_op(key_code);
          b_clr  = k_dig;
          b_shin = k_dig;
        end
        ENTER_B: begin
          b_shin    = k_dig;
          b_shout   = k_bs;
          start_nxt = k_equ;
          if (k_op) op_sel_nxt = key_to_op(key_code);
        end
        EXEC: res_cap = alu_done && !alu_err;
        RESULT: begin
          if (k_dig) begin
            a_clr  = 1'b1;
            a_shin = 1'b1;
            b_clr  = 1'b1;
          end else if (k_op) begin
            a_load     = 1'b1;
            b_clr      = 1'b1;
            op_sel_nxt = key_to_op(key_code);
          end
        end
        default: ;
      endcase
    end
  end

  // registered outputs; display follows the current state, one cycle behind it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_sel_q   <= OP_NONE;
      alu_start  <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
      disp_sel   <= DISP_ZERO;
      disp_value <= '0;
      res_q      <= '0;
      tmo_cnt    <= '0;
    end else begin
      op_sel_q  <= op_sel_nxt;
      alu_start <= start_nxt;
      busy      <= (state_nxt == EXEC);
      error     <= (state_nxt == ERROR);
      if (res_cap) res_q <= alu_result;
      if (k_clr || start_nxt)
        tmo_cnt <= '0;
      else if ((state == EXEC) && !tmo_hit)
        tmo_cnt <= tmo_cnt + TW'(1);
      case (state)
        ENTER_A, OP_WAIT: begin
          disp_sel   <= DISP_A;
          disp_value <= op_a;
        end
        ENTER_B, EXEC: begin
          disp_sel   <= DISP_B;
          disp_value <= op_b;
        end
        RESULT: begin
          disp_sel   <= DISP_RES;
          disp_value <= res_q;
        end
        ERROR: begin
          disp_sel   <= DISP_RES;
          disp_value <= {DIGITS{4'hE}};
        end
        default: begin
          disp_sel   <= DISP_ZERO;
          disp_value <= '0;
        end
      endcase
    end
  end

  assign op_sel = op_sel_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: a per-cycle vector table plus hand-written corner sequences.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;
  logic [15:0] op_a, op_b, disp_value;
  logic [1:0]  op_sel, disp_sel;
  logic        alu_start, busy, error;

  int total = 0;
  int bad   = 0;

  calc_sequencer #(.DIGITS(4), .ALU_TIMEOUT(15)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_sel     (op_sel),
    .alu_start  (alu_start),
    .disp_value (disp_value),
    .disp_sel   (disp_sel),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        dn;
    logic [15:0] rs;
    logic        er_in;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        st;
    logic [1:0]  ds;
    logic [15:0] dv;
    logic        bz;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] kc, input logic dn,
                      input logic [15:0] rs, input logic er);
    @(negedge clk);
    key_valid  = kv;
    key_code   = kc;
    alu_done   = dn;
    alu_result = rs;
    alu_err    = er;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    alu_done  = 1'b0;
    alu_err   = 1'b0;
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b1, k, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    key_valid  = 1'b0;
    key_code   = 4'h0;
    alu_done   = 1'b0;
    alu_result = 16'h0;
    alu_err    = 1'b0;
    resetn     = 1'b0;

    //          kv    kc    dn    rs        err   a         b         op     st    ds     dv        bz    er
    tbl.push_back(vec_t'{1'b1, 4'hD, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 4'h1, 1'b0, 16'h0000, 1'b0, 16'h0001, 16'h0000, 2'd0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 4'h2, 1'b0, 16'h0000, 1'b0, 16'h0012, 16'h0000, 2'd0, 1'b0, 2'd1, 16'h0001, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 4'hA, 1'b0, 16'h0000, 1'b0, 16'h0012, 16'h0000, 2'd1, 1'b0, 2'd1, 16'h0012, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 4'h3, 1'b0, 16'h0000, 1'b0, 16'h0012, 16'h0003, 2'd1, 1'b0, 2'd1, 16'h0012, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 4'h4, 1'b0, 16'h0000, 1'b0, 16'h0012, 16'h0034, 2'd1, 1'b0, 2'd2, 16'h0003, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 4'hD, 1'b0, 16'h0000, 1'b0, 16'h0012, 16'h0034, 2'd1, 1'b1, 2'd2, 16'h0034, 1'b1, 1'b0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0012, 16'h0034, 2'd1, 1'b0, 2'd2, 16'h0034, 1'b1, 1'b0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1'b1, 16'h0046, 1'b0, 16'h0012, 16'h0034, 2'd1, 1'b0, 2'd2, 16'h0034, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0012, 16'h0034, 2'd1, 1'b0, 2'd3, 16'h0046, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 4'hA, 1'b0, 16'h0000, 1'b0, 16'h0046, 16'h0000, 2'd1, 1'b0, 2'd3, 16'h0046, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 4'h4, 1'b0, 16'h0000, 1'b0, 16'h0046, 16'h0004, 2'd1, 1'b0, 2'd1, 16'h0046, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 4'hD, 1'b0, 16'h0000, 1'b0, 16'h0046, 16'h0004, 2'd1, 1'b1, 2'd2, 16'h0004, 1'b1, 1'b0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1'b1, 16'h0050, 1'b0, 16'h0046, 16'h0004, 2'd1, 1'b0, 2'd2, 16'h0004, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 4'hC, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 2'd3, 16'h0050, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0});

    // reset values while reset is held
    #12;
    chk("rst_op_a", op_a, 16'h0);
    chk("rst_op_b", op_b, 16'h0);
    chk("rst_op_sel", 16'(op_sel), 16'h0);
    chk("rst_disp", disp_value, 16'h0);
    chk("rst_flags", 16'({alu_start, busy, error, disp_sel}), 16'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].kv, tbl[i].kc, tbl[i].dn, tbl[i].rs, tbl[i].er_in);
      chk($sformatf("v%0d_op_a", i), op_a, tbl[i].a);
      chk($sformatf("v%0d_op_b", i), op_b, tbl[i].b);
      chk($sformatf("v%0d_op_sel", i), 16'(op_sel), 16'(tbl[i].op));
      chk($sformatf("v%0d_alu_start", i), 16'(alu_start), 16'(tbl[i].st));
      chk($sformatf("v%0d_disp_sel", i), 16'(disp_sel), 16'(tbl[i].ds));
      chk($sformatf("v%0d_disp_value", i), disp_value, tbl[i].dv);
      chk($sformatf("v%0d_busy", i), 16'(busy), 16'(tbl[i].bz));
      chk($sformatf("v%0d_error", i), 16'(error), 16'(tbl[i].er));
    end

    // leading zeros do not count as digits
    key(4'h0); key(4'h0); key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5);
    chk("lz_op_a", op_a, 16'h1234);
    key(4'hC); idle();

    // fifth digit is dropped
    key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'h5);
    chk("full_op_a", op_a, 16'h9876);
    idle();
    chk("full_disp_sel", 16'(disp_sel), 16'h1);
    chk("full_disp_value", disp_value, 16'h9876);
    key(4'hC); idle();

    // ALU timeout
    key(4'h5); key(4'hB); key(4'h7); key(4'hD);
    chk("tmo_start", 16'(alu_start), 16'h1);
    chk("tmo_op_sel", 16'(op_sel), 16'h2);
    for (int i = 0; i < 15; i++) idle();
    chk("tmo_not_yet", 16'({busy, error}), 16'b10);
    idle();
    chk("tmo_error", 16'({busy, error}), 16'b01);
    idle();
    chk("tmo_disp_sel", 16'(disp_sel), 16'h3);
    chk("tmo_disp_value", disp_value, 16'hEEEE);
    key(4'h3);
    chk("err_key_ignored", 16'({error, op_b[3:0]}), 16'h17);
    key(4'hC);
    chk("err_clr_flags", 16'({alu_start, busy, error, op_sel}), 16'h0);
    chk("err_clr_ops", op_a | op_b, 16'h0);
    idle();
    chk("err_clr_disp", 16'(disp_sel) | disp_value, 16'h0);

    // abort in EXEC, late done ignored
    key(4'h2); key(4'hE); key(4'h3); key(4'hD);
    chk("abort_busy_pre", 16'(busy), 16'h1);
    key(4'hC);
    chk("abort_busy", 16'(busy), 16'h0);
    step(1'b0, 4'h0, 1'b1, 16'h0006, 1'b0);
    idle();
    chk("abort_disp_sel", 16'(disp_sel), 16'h0);
    chk("abort_disp_value", disp_value, 16'h0000);

    // C and done in the same cycle: C wins
    key(4'h2); key(4'hE); key(4'h3); key(4'hD);
    step(1'b1, 4'hC, 1'b1, 16'h0099, 1'b0);
    idle();
    chk("clr_vs_done_disp", 16'(disp_sel), 16'h0);
    chk("clr_vs_done_flags", 16'({busy, error, op_sel}), 16'h0);

    // ALU reports error
    key(4'h1); key(4'hA); key(4'h1); key(4'hD);
    step(1'b0, 4'h0, 1'b1, 16'h0000, 1'b1);
    chk("alu_err_flag", 16'(error), 16'h1);
    idle();
    chk("alu_err_disp", disp_value, 16'hEEEE);
    key(4'hC); idle();

    // key F: backspace when compiled in, ignored otherwise
    key(4'h1); key(4'h2); key(4'h3); key(4'hF);
`ifdef CALC_SEQ_BACKSPACE_EN
    chk("bs_op_a", op_a, 16'h0012);
    key(4'hF); key(4'hF);
    chk("bs_empty_op_a", op_a, 16'h0000);
    idle();
    chk("bs_idle_disp_sel", 16'(disp_sel), 16'h0);
`else
    chk("f_ignored_op_a", op_a, 16'h0123);
    idle();
    chk("f_ignored_disp_sel", 16'(disp_sel), 16'h1);
`endif
    key(4'hC); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
